// File: rtl/minimig_reset_ctrl.sv
// Reset scheduler: merges all reset sources into a sequenced peripheral/CPU reset pair
// and owns the bootrom mapping flag.
module minimig_reset_ctrl #(
   parameter int HOLD_CNT = 4,
   parameter int STAGGER  = 8,
   parameter int RSTI_LEN = 124
) (
   input  logic       clk,
   input  logic       _rst,
   input  logic       clk7_en,
   input  logic       cnt,
   input  logic       hps_rst,
   input  logic       kbd_rst,
   input  logic       hps_cold,
   input  logic       boot_done,
   input  logic       cpu_rsti,
   output logic       reset_periph,
   output logic       reset_cpu,
   output logic       boot,
   output logic       busy,
   output logic [2:0] cause
);

   localparam int HW = $clog2(HOLD_CNT + 1);
   localparam int SW = $clog2(STAGGER + 1);
   localparam int RW = $clog2(RSTI_LEN + 1);

   typedef enum logic [2:0] {S_HOLD, S_DRAIN, S_STAG, S_RUN, S_RSTI} state_t;

   state_t        state, state_n;
   logic [HW-1:0] hold_cnt, hold_n;
   logic [SW-1:0] stg_cnt, stg_n;
   logic [RW-1:0] rsti_cnt, rsti_n;
   logic [2:0]    cause_n;
   logic          boot_n;
   logic          hps_s1, hps_s2, hps_s3;
   logic          kbd_s1, kbd_s2, kbd_s3;
   logic          hps_rise, kbd_rise, bd_ok, req;
   logic [2:0]    req_cause;

   // A level held asserted counts as one request (its rising edge); DRAIN waits it out.
   always_comb begin
      hps_rise  = hps_s2 & ~hps_s3;
      kbd_rise  = kbd_s2 & ~kbd_s3;
      bd_ok     = boot_done & boot;
      req       = hps_cold | hps_rise | kbd_rise | bd_ok;
      req_cause = hps_cold ? 3'd2 :
                  hps_rise ? 3'd3 :
                  kbd_rise ? 3'd4 : 3'd5;
   end

   always_comb begin
      state_n = state;
      hold_n  = hold_cnt;
      stg_n   = stg_cnt;
      rsti_n  = rsti_cnt;
      cause_n = cause;
      boot_n  = boot;
      if (clk7_en) begin
         if (hps_cold)
            boot_n = 1'b1;
         else if (bd_ok)
            boot_n = 1'b0;

         if (req) begin
            state_n = S_HOLD;
            hold_n  = '0;
            cause_n = req_cause;
         end else begin
            unique case (state)
               S_HOLD: begin
                  if (hold_cnt == HW'(HOLD_CNT))
                     state_n = S_DRAIN;
                  else if (cnt)
                     hold_n = hold_cnt + 1'b1;
               end
               S_DRAIN: begin
                  if (!hps_s2 && !kbd_s2) begin
                     state_n = S_STAG;
                     stg_n   = '0;
                  end
               end
               S_STAG: begin
                  if (stg_cnt == SW'(STAGGER - 1))
                     state_n = S_RUN;
                  else
                     stg_n = stg_cnt + 1'b1;
               end
               S_RUN: begin
                  if (cpu_rsti) begin
                     state_n = S_RSTI;
                     rsti_n  = '0;
                     cause_n = 3'd6;
                  end
               end
               S_RSTI: begin
                  if (rsti_cnt == RW'(RSTI_LEN - 1))
                     state_n = S_RUN;
                  else
                     rsti_n = rsti_cnt + 1'b1;
               end
               default: state_n = S_HOLD;
            endcase
         end
      end
   end

   // Outputs are registered from the next state so they change on the accepting edge.
   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) begin
         state        <= S_HOLD;
         hold_cnt     <= '0;
         stg_cnt      <= '0;
         rsti_cnt     <= '0;
         hps_s1       <= 1'b0;
         hps_s2       <= 1'b0;
         hps_s3       <= 1'b0;
         kbd_s1       <= 1'b0;
         kbd_s2       <= 1'b0;
         kbd_s3       <= 1'b0;
         reset_periph <= 1'b1;
         reset_cpu    <= 1'b1;
         boot         <= 1'b1;
         busy         <= 1'b1;
         cause        <= 3'd1;
      end else begin
         if (clk7_en) begin
            hps_s1 <= hps_rst;
            hps_s2 <= hps_s1;
            hps_s3 <= hps_s2;
            kbd_s1 <= kbd_rst;
            kbd_s2 <= kbd_s1;
            kbd_s3 <= kbd_s2;
         end
         state        <= state_n;
         hold_cnt     <= hold_n;
         stg_cnt      <= stg_n;
         rsti_cnt     <= rsti_n;
         boot         <= boot_n;
         cause        <= cause_n;
         reset_periph <= !(state_n == S_RUN || state_n == S_STAG);
         reset_cpu    <= !(state_n == S_RUN || state_n == S_RSTI);
         busy         <= (state_n != S_RUN);
      end
   end

endmodule
